// File: rtl/softmax_normalize_pkg.sv
// Shared types, default widths and the output saturation helper.
package softmax_normalize_pkg;

  typedef enum logic [1:0] {
    S_ACCUM  = 2'd0,
    S_LOOKUP = 2'd1,
    S_WAIT   = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  localparam int N_CLASS_D   = 5;
  localparam int DATA_W_D    = 16;
  localparam int INV_W_D     = 16;
  localparam int INV_FRAC_D  = 12;
  localparam int ADDR_W_D    = 10;
  localparam int SUM_SHIFT_D = 6;

  // Clamp a signed value into [0, 2^(w-1)-1]; probabilities are never negative.
  function automatic logic [47:0] sat_u(input logic signed [47:0] v, input int w);
    logic signed [47:0] max;
    max = (48'sd1 <<< (w - 1)) - 48'sd1;
    if (v < 48'sd0)    return '0;
    else if (v > max)  return max;
    else               return v;
  endfunction

endpackage

// File: rtl/softmax_norm_mul.sv
// Multiply by reciprocal, rescale, saturate; single output register with skid hold.
module softmax_norm_mul
  import softmax_normalize_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int INV_W    = INV_W_D,
  parameter int INV_FRAC = INV_FRAC_D
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [INV_W-1:0]  i_inv,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);
  localparam int PW = DATA_W + INV_W;

  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;
  logic signed [47:0]   w_ext;
  logic [47:0]          w_sat;
  logic                 w_unused_sat;

  assign w_prod  = $signed({{INV_W{i_data[DATA_W-1]}}, i_data}) *
                   $signed({{DATA_W{i_inv[INV_W-1]}}, i_inv});
  // Arithmetic shift floors toward -inf before saturation.
  assign w_shift = w_prod >>> INV_FRAC;
  assign w_ext   = {{(48-PW){w_shift[PW-1]}}, w_shift};
  assign w_sat   = sat_u(w_ext, DATA_W);
  assign w_unused_sat = ^w_sat[47:DATA_W];

  // Load a new beat when issued; otherwise drop valid once consumed, hold data while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= w_sat[DATA_W-1:0];
      o_last  <= i_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_normalize.sv
// Buffers one exponent vector, looks up 1/sum in an external ROM, emits probabilities.
module softmax_normalize
  import softmax_normalize_pkg::*;
#(
  parameter int N_CLASS   = N_CLASS_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int INV_W     = INV_W_D,
  parameter int INV_FRAC  = INV_FRAC_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int SUM_SHIFT = SUM_SHIFT_D
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic [ADDR_W-1:0] o_inv_addr,
  input  logic [INV_W-1:0]  i_inv_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last
);
  localparam int CNT_W = $clog2(N_CLASS);
  localparam int SUM_W = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(N_CLASS - 1);
  localparam logic [SUM_W-1:0] MAX_A  = SUM_W'((1 << (ADDR_W - 1)) - 1);

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_buf [N_CLASS];
  logic [SUM_W-1:0]    r_sum;
  logic [CNT_W-1:0]    r_cnt, r_idx;
  logic                r_done;
  logic [INV_W-1:0]    r_inv;
  logic [ADDR_W-1:0]   r_inv_addr;
  logic                r_in_ready;

  logic                w_acc, w_last_in, w_load, w_cap, w_fin;
  logic [SUM_W-1:0]    w_sum_nxt, w_addr_raw;
  logic [ADDR_W-1:0]   w_addr_clamp;

  assign o_in_ready = r_in_ready;
  assign o_inv_addr = r_inv_addr;

  assign w_acc      = i_in_valid & r_in_ready;
  assign w_last_in  = w_acc & (r_cnt == LAST_I);
  assign w_sum_nxt  = r_sum + SUM_W'(i_in_data);
  assign w_addr_raw = w_sum_nxt >> SUM_SHIFT;
  assign w_fin      = o_out_valid & i_out_ready & o_out_last;

  // Address for the completed sum: never entry 0, never the upper (invalid) half.
  always_comb begin
    w_addr_clamp = w_addr_raw[ADDR_W-1:0];
    if (w_addr_raw == '0)        w_addr_clamp = ADDR_W'(1);
    else if (w_addr_raw > MAX_A) w_addr_clamp = MAX_A[ADDR_W-1:0];
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_ACCUM;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ACCUM:  if (w_last_in) w_next = S_LOOKUP;
      S_LOOKUP: w_next = S_WAIT;
      S_WAIT:   w_next = S_EMIT;
      S_EMIT:   if (w_fin) w_next = S_ACCUM;
      default:  w_next = S_ACCUM;
    endcase
  end

  // State-decoded controls: capture reciprocal in WAIT, issue beats in EMIT as the skid frees.
  always_comb begin
    w_cap  = (r_state == S_WAIT);
    w_load = (r_state == S_EMIT) & ~r_done & (~o_out_valid | i_out_ready);
  end

  // Accumulation, reciprocal capture and emit indexing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CLASS; i++) r_buf[i] <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_inv      <= '0;
      r_inv_addr <= '0;
      r_in_ready <= 1'b0;
    end else begin
      // Registered so in_ready stays low during reset and rises on the first edge after.
      r_in_ready <= (w_next == S_ACCUM);
      if (w_acc) begin
        r_buf[r_cnt] <= i_in_data;
        r_sum        <= w_sum_nxt;
        r_cnt        <= w_last_in ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_last_in) r_inv_addr <= w_addr_clamp;
      if (w_cap)     r_inv      <= i_inv_data;
      if (w_load) begin
        r_idx  <= (r_idx == LAST_I) ? '0 : r_idx + CNT_W'(1);
        r_done <= (r_idx == LAST_I);
      end
      if (w_fin) begin
        r_sum  <= '0;
        r_done <= 1'b0;
      end
    end
  end

  softmax_norm_mul #(
    .DATA_W  (DATA_W),
    .INV_W   (INV_W),
    .INV_FRAC(INV_FRAC)
  ) u_mul (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (w_load),
    .i_data (r_buf[r_idx]),
    .i_inv  (r_inv),
    .i_last (r_idx == LAST_I),
    .i_ready(i_out_ready),
    .o_valid(o_out_valid),
    .o_data (o_out_data),
    .o_last (o_out_last)
  );

endmodule

// File: tb/tb_softmax_normalize.sv
// Bench for softmax_normalize: vector table + scoreboard, external reciprocal ROM.
module tb_softmax_normalize;
  localparam int N = 5;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_data = '0;
  logic [9:0]  inv_addr;
  logic [15:0] inv_data;
  logic        out_valid, out_ready = 1'b1, out_last;
  logic [15:0] out_data;

  softmax_normalize dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .o_inv_addr(inv_addr), .i_inv_data(inv_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous reciprocal ROM; upper half holds a negative marker.
  logic [15:0] rom [1024];
  initial begin
    rom[0] = 16'h7FFF;
    for (int i = 1; i < 512; i++) rom[i] = 16'((8192 + i) / (2 * i));
    for (int i = 512; i < 1024; i++) rom[i] = 16'h8000;
  end
  always @(posedge clk) inv_data <= rom[inv_addr];

  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  logic        last_q[$];
  bit          bp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream: always ready, or the 1,0,0,1 pattern under backpressure.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      if (bp) begin out_ready = (k % 4 == 0) || (k % 4 == 3); k++; end
      else out_ready = 1'b1;
    end
  end

  // Output monitor: hold stability, busy in_ready, scoreboard compare.
  initial begin
    bit prev_stall = 1'b0;
    logic [15:0] hd;
    logic hl;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hd);
        chk("hold_last", out_last, hl);
      end
      if (out_valid) chk("in_ready_busy", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", out_data, 16'hDEAD);
        else begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_last", out_last, last_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready && rst_n;
      hd = out_data; hl = out_last;
    end
  end

  task automatic drive_beat(input logic [15:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("in_ready_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0][15:0] d;
    int                 addr;
    logic [N-1:0][15:0] e;
    bit                 bp;
    bit                 gaps;
  } vec_t;

  // Independent reference: reciprocal by rounding division, floor multiply, clamp.
  function automatic void model(inout vec_t v);
    int s = 0, a, inv;
    longint p;
    for (int i = 0; i < N; i++) s += int'(v.d[i]);
    a = s >> 6;
    if (a < 1) a = 1;
    if (a > 511) a = 511;
    inv = (8192 + a) / (2 * a);
    v.addr = a;
    for (int i = 0; i < N; i++) begin
      p = (longint'(v.d[i]) * inv) >>> 12;
      v.e[i] = (p > 32767) ? 16'd32767 : 16'(p);
    end
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    bp = v.bp;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(v.e[i]);
      last_q.push_back(i == N - 1);
    end
    for (int i = 0; i < N; i++) begin
      if (v.gaps && (i % 2 == 1)) repeat (2) begin @(posedge clk); #1; end
      drive_beat(v.d[i]);
    end
    chk({tag, "_inv_addr"}, inv_addr, v.addr);
    chk({tag, "_in_ready_lookup"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_latency"}, n, 3);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, "_drain"}, exp_q.size(), 0);
    @(posedge clk); #1;
    bp = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_inv_addr"}, inv_addr, 0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0].d = {5{16'd64}};  tbl[0].addr = 5;   tbl[0].e = {5{16'd12}};
    tbl[0].bp = 0; tbl[0].gaps = 0;
    tbl[1].d = {16'd0, 16'd0, 16'd0, 16'd0, 16'd640}; tbl[1].addr = 10;
    tbl[1].e = {16'd0, 16'd0, 16'd0, 16'd0, 16'd64}; tbl[1].bp = 0; tbl[1].gaps = 0;
    tbl[2].d = {5{16'd0}};   tbl[2].addr = 1;   tbl[2].e = {5{16'd0}};
    tbl[2].bp = 0; tbl[2].gaps = 0;
    tbl[3].d = {5{16'd32767}}; tbl[3].addr = 511; tbl[3].e = {5{16'd63}};
    tbl[3].bp = 0; tbl[3].gaps = 0;
    tbl[4].d = {16'd500, 16'd400, 16'd300, 16'd200, 16'd100}; tbl[4].addr = 23;
    tbl[4].e = {16'd21, 16'd17, 16'd13, 16'd8, 16'd4}; tbl[4].bp = 1; tbl[4].gaps = 1;
    for (int i = 0; i < N; i++) tbl[5].d[i] = 16'($urandom_range(0, 4000));
    tbl[5].bp = 1; tbl[5].gaps = 0;
    model(tbl[5]);

    #2;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);

    for (int t = 0; t < 6; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Partial vector, then asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) drive_beat(16'd64);
    #3 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(tbl[0], "post_reset");
    repeat (10) @(posedge clk);
    chk("no_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
